// File: rtl/riscv_mul_sched_if.sv
// Requester/multiplier bundle for riscv_mul_sched: two request/response ports plus the shared multiplier port.
// Handshake: reqN_valid may be asserted at any time; the op is accepted in a cycle where reqN_valid && reqN_ready;
// reqN_ready is combinational and never high for both requesters; responses have no backpressure.
interface riscv_mul_sched_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [1:0]      req0_func;
    logic [XLEN-1:0] req0_opA;
    logic [XLEN-1:0] req0_opB;

    logic            req1_valid;
    logic            req1_ready;
    logic [1:0]      req1_func;
    logic [XLEN-1:0] req1_opA;
    logic [XLEN-1:0] req1_opB;

    logic            mul_valid;
    logic [1:0]      mul_func;
    logic [XLEN-1:0] mul_opA;
    logic [XLEN-1:0] mul_opB;
    logic [XLEN-1:0] mul_r;

    logic            rsp0_valid;
    logic [XLEN-1:0] rsp0_r;
    logic            rsp1_valid;
    logic [XLEN-1:0] rsp1_r;

    modport slave (
        input  req0_valid, req0_func, req0_opA, req0_opB,
        input  req1_valid, req1_func, req1_opA, req1_opB,
        input  mul_r,
        output req0_ready, req1_ready,
        output mul_valid, mul_func, mul_opA, mul_opB,
        output rsp0_valid, rsp0_r, rsp1_valid, rsp1_r
    );

    modport master (
        output req0_valid, req0_func, req0_opA, req0_opB,
        output req1_valid, req1_func, req1_opA, req1_opB,
        output mul_r,
        input  req0_ready, req1_ready,
        input  mul_valid, mul_func, mul_opA, mul_opB,
        input  rsp0_valid, rsp0_r, rsp1_valid, rsp1_r
    );
endinterface

// File: rtl/riscv_mul_sched.sv
// Two-requester scheduler for one pipelined multiplier; tags ops and steers results back after LATENCY cycles.
// Optional macro RISCV_MUL_SCHED_FIXED_PRIO_EN: requester 0 always wins (default build is round-robin).
module riscv_mul_sched #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               idle,
    riscv_mul_sched_if.slave   bus
);
    localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > 3) ? 3 : LATENCY);

    generate
        if (LATENCY < 1 || LATENCY > 3) begin : g_lat_warn
            $warning("riscv_mul_sched: LATENCY out of range 1..3, clamped");
        end
    endgenerate

    logic            w_any;
    logic            w_hs;
    logic            w_gnt_id;
    logic [1:0]      w_sel_func;
    logic [XLEN-1:0] w_sel_opA;
    logic [XLEN-1:0] w_sel_opB;
    logic            w_ret;

    logic            r_mul_valid;
    logic [1:0]      r_mul_func;
    logic [XLEN-1:0] r_mul_opA;
    logic [XLEN-1:0] r_mul_opB;
    logic [LAT:0]    r_pipe_v;
    logic [LAT:0]    r_pipe_tag;
    logic            r_rsp0_valid;
    logic [XLEN-1:0] r_rsp0_r;
    logic            r_rsp1_valid;
    logic [XLEN-1:0] r_rsp1_r;

    assign w_any = bus.req0_valid | bus.req1_valid;
    assign w_hs  = w_any & ~flush;

`ifdef RISCV_MUL_SCHED_FIXED_PRIO_EN
    assign w_gnt_id = ~bus.req0_valid;
`else
    logic r_last_grant;

    always_comb begin
        w_gnt_id = ~bus.req0_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt_id = ~r_last_grant;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contended cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_last_grant <= w_gnt_id;
        end
    end
`endif

    assign bus.req0_ready = w_hs & ~w_gnt_id;
    assign bus.req1_ready = w_hs &  w_gnt_id;

    assign w_sel_func = w_gnt_id ? bus.req1_func : bus.req0_func;
    assign w_sel_opA  = w_gnt_id ? bus.req1_opA  : bus.req0_opA;
    assign w_sel_opB  = w_gnt_id ? bus.req1_opB  : bus.req0_opB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_valid <= 1'b0;
            r_mul_func  <= 2'd0;
            r_mul_opA   <= '0;
            r_mul_opB   <= '0;
        end else begin
            r_mul_valid <= w_hs;
            if (w_hs) begin
                r_mul_func <= w_sel_func;
                r_mul_opA  <= w_sel_opA;
                r_mul_opB  <= w_sel_opB;
            end
        end
    end

    // Stage 0 lines up with mul_valid; stage LAT lines up with the cycle mul_r is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_v   <= '0;
            r_pipe_tag <= '0;
        end else begin
            r_pipe_tag <= {r_pipe_tag[LAT-1:0], w_gnt_id};
            if (flush) begin
                r_pipe_v <= '0;
            end else begin
                r_pipe_v <= {r_pipe_v[LAT-1:0], w_hs};
            end
        end
    end

    // A result arriving during a flush belongs to killed work and is dropped.
    assign w_ret = r_pipe_v[LAT] & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_r     <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_r     <= '0;
        end else begin
            r_rsp0_valid <= w_ret & ~r_pipe_tag[LAT];
            r_rsp1_valid <= w_ret &  r_pipe_tag[LAT];
            if (w_ret && !r_pipe_tag[LAT]) begin
                r_rsp0_r <= bus.mul_r;
            end
            if (w_ret && r_pipe_tag[LAT]) begin
                r_rsp1_r <= bus.mul_r;
            end
        end
    end

    assign bus.mul_valid  = r_mul_valid;
    assign bus.mul_func   = r_mul_func;
    assign bus.mul_opA    = r_mul_opA;
    assign bus.mul_opB    = r_mul_opB;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp0_r     = r_rsp0_r;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp1_r     = r_rsp1_r;

    assign idle = ~(|r_pipe_v) & ~r_mul_valid & ~w_hs;
endmodule

// File: tb/tb_riscv_mul_sched.sv
// Directed bench for riscv_mul_sched: behavioural multiplier, expected-response queues and a response monitor.
module tb_riscv_mul_sched;
    localparam int XLEN = 32;
    localparam int L    = 2;

    logic clk;
    logic rst;
    logic flush;
    logic idle;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [XLEN-1:0] exp0_q[$];
    logic [XLEN-1:0] exp1_q[$];
    int              exp0_t[$];
    int              exp1_t[$];

    riscv_mul_sched_if #(.XLEN(XLEN)) bus();

    riscv_mul_sched #(.XLEN(XLEN), .LATENCY(L)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .idle  (idle),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // behavioural multiplier with L cycles of latency
    function automatic logic [XLEN-1:0] mulf(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [63:0] pu;
        logic signed [63:0] ps;
        pu = {32'b0, a} * {32'b0, b};
        ps = 64'sd0;
        case (f)
            2'd1: ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd2: ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            default: ps = 64'sd0;
        endcase
        case (f)
            2'd0: mulf = pu[31:0];
            2'd3: mulf = pu[63:32];
            default: mulf = ps[63:32];
        endcase
    endfunction

    logic [XLEN-1:0] m_pipe [0:L-1];
    always @(posedge clk) begin
        m_pipe[0] <= bus.mul_valid ? mulf(bus.mul_func, bus.mul_opA, bus.mul_opB) : '0;
        for (int k = 1; k < L; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign bus.mul_r = m_pipe[L-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: one cycle of stimulus, ready check at negedge, inputs cleared afterwards
    task automatic step(input bit v0, input logic [1:0] f0, input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0,
                        input bit v1, input logic [1:0] f1, input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                        input bit fl, input bit er0, input bit er1, input bit kill);
        bus.req0_valid = v0; bus.req0_func = f0; bus.req0_opA = a0; bus.req0_opB = b0;
        bus.req1_valid = v1; bus.req1_func = f1; bus.req1_opA = a1; bus.req1_opB = b1;
        flush = fl;
        @(negedge clk);
        check("req0_ready", {63'b0, bus.req0_ready}, {63'b0, er0});
        check("req1_ready", {63'b0, bus.req1_ready}, {63'b0, er1});
        if (er0 && !kill) begin exp0_q.push_back(e0); exp0_t.push_back(cyc + L + 2); end
        if (er1 && !kill) begin exp1_q.push_back(e1); exp1_t.push_back(cyc + L + 2); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req0_func = 2'd0; bus.req0_opA = '0; bus.req0_opB = '0;
        bus.req1_valid = 1'b0; bus.req1_func = 2'd0; bus.req1_opA = '0; bus.req1_opB = '0;
        flush = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp0_valid) begin
                if (exp0_q.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
                else begin
                    check("rsp0_data", {32'b0, bus.rsp0_r}, {32'b0, exp0_q.pop_front()});
                    check("rsp0_cycle", 64'(cyc), 64'(exp0_t.pop_front()));
                end
            end
            if (bus.rsp1_valid) begin
                if (exp1_q.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
                else begin
                    check("rsp1_data", {32'b0, bus.rsp1_r}, {32'b0, exp1_q.pop_front()});
                    check("rsp1_cycle", 64'(cyc), 64'(exp1_t.pop_front()));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_idle"}, {63'b0, idle}, 64'd1);
        check({tag, "_mul_valid"}, {63'b0, bus.mul_valid}, 64'd0);
        check({tag, "_mul_func"}, {62'b0, bus.mul_func}, 64'd0);
        check({tag, "_mul_opA"}, {32'b0, bus.mul_opA}, 64'd0);
        check({tag, "_mul_opB"}, {32'b0, bus.mul_opB}, 64'd0);
        check({tag, "_rsp0_valid"}, {63'b0, bus.rsp0_valid}, 64'd0);
        check({tag, "_rsp1_valid"}, {63'b0, bus.rsp1_valid}, 64'd0);
        check({tag, "_rsp0_r"}, {32'b0, bus.rsp0_r}, 64'd0);
        check({tag, "_rsp1_r"}, {32'b0, bus.rsp1_r}, 64'd0);
    endtask

    initial begin
        int  idx0;
        int  idx1;
        bit  er0;
        bit  er1;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_func = 2'd0; bus.req0_opA = '0; bus.req0_opB = '0;
        bus.req1_valid = 1'b0; bus.req1_func = 2'd0; bus.req1_opA = '0; bus.req1_opB = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        // both requesters contend for four cycles; each keeps its op until granted
        idx0 = 0;
        idx1 = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef RISCV_MUL_SCHED_FIXED_PRIO_EN
            er0 = 1'b1;
            er1 = 1'b0;
`else
            er0 = (i % 2 == 0);
            er1 = (i % 2 == 1);
`endif
            step(1, 0, idx0 + 1, 10, (idx0 + 1) * 10, 1, 0, idx1 + 1, 20, (idx1 + 1) * 20, 0, er0, er1, 0);
            if (er0) idx0++;
            if (er1) idx1++;
        end
        idle_steps(6);

        // single MUL on requester 0
        step(1, 0, 3, 5, 15, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("issue_mul_valid", {63'b0, bus.mul_valid}, 64'd1);
        check("issue_mul_opA", {32'b0, bus.mul_opA}, 64'd3);
        check("issue_mul_opB", {32'b0, bus.mul_opB}, 64'd5);
        check("issue_idle", {63'b0, idle}, 64'd0);
        idle_steps(5);

        // requester 1 back-to-back
        step(0, 0, 0, 0, 0, 1, 0, 7, 2, 14, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 7, 3, 21, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 7, 4, 28, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 7, 5, 35, 0, 0, 1, 0);
        idle_steps(5);

        // high-half functions
        step(1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("issue_mul_func", {62'b0, bus.mul_func}, 64'd3);
        step(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0, 0, 1, 0);
        step(1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_steps(5);

        // flush two cycles after issue: op is killed, scheduler idle afterwards
        step(1, 0, 6, 7, 42, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle_steps(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("flush_idle", {63'b0, idle}, 64'd1);
        check("flush_mul_valid", {63'b0, bus.mul_valid}, 64'd0);
        idle_steps(4);

        // flush in the cycle the result arrives: response dropped
        step(1, 0, 5, 5, 25, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle_steps(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_steps(4);

        // flush in the cycle a response is already visible: that response completes
        step(1, 0, 4, 4, 16, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_steps(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_steps(3);

        // flush with requester 1 valid: no grant, granted next cycle
        step(0, 0, 0, 0, 0, 1, 0, 9, 9, 81, 1, 0, 0, 0);
        check("flush_next_mul_valid", {63'b0, bus.mul_valid}, 64'd0);
        step(0, 0, 0, 0, 0, 1, 0, 9, 9, 81, 0, 0, 1, 0);
        idle_steps(5);

        // asynchronous reset with two ops in flight
        step(1, 0, 11, 11, 121, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 12, 12, 144, 0, 0, 1, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        idle_steps(6);

        // requester 0 wins the first contended cycle after reset
        step(1, 0, 2, 3, 6, 1, 0, 4, 5, 20, 0, 1, 0, 0);
        idle_steps(10);

        check("drain_rsp0", 64'(exp0_q.size()), 64'd0);
        check("drain_rsp1", 64'(exp1_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_mul_sched.md
Name: riscv_mul_sched

Overview:
- Scheduler that shares one fixed-latency, fully pipelined multiplier datapath between two requesters, e.g. the integer pipe and a second hart/accelerator port.
- Arbitrates round-robin, issues one operation per cycle and tags each in-flight op.
- Steers each result back to its owner after exactly LATENCY cycles.
- Supports flush of in-flight work and reports an idle status.

Parameters:
- XLEN, 32, operand/result width.
- LATENCY, 2, multiplier issue-to-result latency in cycles; legal 1..3. Values outside this range are clamped and flagged with a simulation warning.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- flush  input  1  kill all in-flight ops; no grant this cycle
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle (combinational)
- req0_func  input  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
- req0_opA  input  XLEN  operand A
- req0_opB  input  XLEN  operand B
- req1_valid, req1_ready, req1_func, req1_opA, req1_opB: same as requester 0
- mul_valid  output  1  op issued to multiplier (registered)
- mul_func  output  2  issued function (registered)
- mul_opA  output  XLEN  issued operand A (registered)
- mul_opB  output  XLEN  issued operand B (registered)
- mul_r  input  XLEN  multiplier result, valid LATENCY cycles after the mul_valid cycle
- rsp0_valid  output  1  result for requester 0 (registered)
- rsp0_r  output  XLEN  result data for requester 0
- rsp1_valid, rsp1_r: same for requester 1
- idle  output  1  no op in flight, no response pending

Behaviour:
- Reset: mul_valid, rsp0_valid, rsp1_valid = 0; mul_func, mul_opA, mul_opB, rsp0_r, rsp1_r = 0; idle = 1; last_grant = 1, so requester 0 wins first; tag pipe cleared.
  - Reset mid-operation discards everything; no stale response ever appears.
- Arbitration, combinational:
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the requester not equal to last_grant.
  - last_grant updates only on a handshake.
  - reqN_ready = grant to N and !flush. At most one ready per cycle.
- Issue: a handshake in cycle t registers func/opA/opB onto the mul_* ports with mul_valid=1 in cycle t+1. With no handshake, mul_valid=0 and the data regs hold.
- Tag tracking: shift register of {valid, tag} pairs, depth LATENCY+1, aligned to mul_valid. At the cycle mul_r is valid for an op, the stage with valid=1 and tag N loads rspN_r <= mul_r and pulses rspN_valid for one cycle; the other rsp_valid is 0.
  - Handshake-to-response latency: LATENCY+2 cycles (handshake t, response visible t+LATENCY+2).
- Throughput: 1 op/cycle sustained. Responses return in issue order with no reordering. No response backpressure; requesters must always accept.
- rspN_r holds its last value when rspN_valid=0.
- Flush:
  - In the flush cycle, readies are forced 0 and all tag-pipe valid bits are cleared.
  - mul_valid is 0 in the next cycle.
  - No response is produced for any op issued before or during the flush.
  - A response already registered in the flush cycle still completes.
- idle = 1 iff all tag-pipe valids = 0, mul_valid = 0 and no handshake this cycle.
- Simultaneous flush and reqN_valid: no grant and last_grant unchanged; arbitration resumes next cycle.

Optional Feature:
- Macro RISCV_MUL_SCHED_FIXED_PRIO_EN.
  - Defined: fixed priority. Requester 0 always wins when both are valid, and last_grant is unused.
  - Undefined: round-robin as above.
- All other behaviour is identical either way.

Test Plan:
- LATENCY=2, req0 MUL opA=3 opB=5 in cycle 0 -> req0_ready=1 in cycle 0; mul_valid=1 in cycle 1 with opA=3 opB=5; model returns 15 in cycle 3; rsp0_valid=1, rsp0_r=15 in cycle 4; rsp1_valid stays 0.
- Both requesters valid in cycles 0-3 (A operands 1,2,3,4 per requester) -> grants 0,1,0,1; rsp0, rsp1, rsp0, rsp1 pulse in cycles 4, 5, 6, 7 with the matching products.
- req1 back-to-back 4 ops (7x2, 7x3, 7x4, 7x5) -> req1_ready high in cycles 0-3; rsp1_valid high in cycles 4-7 with values 14, 21, 28, 35.
- req0 issue in cycle 0, flush=1 in cycle 2 -> no rsp0_valid in cycle 4; idle=1 from cycle 3; a req1 request in cycle 2 gets ready=0 and is granted in cycle 3.
- rst asserted in cycle 2 with 2 ops in flight -> all outputs at reset values immediately (asynchronous); no rsp_valid after rst deasserts.
- RISCV_MUL_SCHED_FIXED_PRIO_EN defined, both valid in cycles 0-3 -> req0_ready=1 in all four cycles, req1_ready=0 throughout.
